// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch front end.
// The fetch bundle width is fixed here because the queue entry struct
// is sized by it; the top-level FETCH_WORDS parameter must match.
package fetch_pkg;

    localparam int INST_W         = 32;
    localparam int FQ_FETCH_WORDS = 2;
    localparam int FQ_OFF_W       = $clog2(FQ_FETCH_WORDS);

    // One buffered fetch bundle: raw words, aligned address of word 0,
    // and the index of the next word still to be handed to decode.
    typedef struct packed {
        logic [FQ_FETCH_WORDS*INST_W-1:0] data;
        logic [31:0]                      base;
        logic [FQ_OFF_W-1:0]              idx;
    } fq_entry_t;

    // Clear the byte offset within a fetch bundle.
    function automatic logic [31:0] bundle_align(input logic [31:0] addr);
        return addr & ~(32'(FQ_FETCH_WORDS * 4) - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular bundle queue with flush and in-place update of the head entry's
// consume index. An entry is popped once its last word has been taken.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  fq_entry_t         push_entry,
    input  logic [FQ_OFF_W:0] take,
    output fq_entry_t         head_entry,
    output logic              head_valid,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IDX_W = FQ_OFF_W + 1;

    fq_entry_t        entry_mem [DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic [IDX_W-1:0] idx_sum;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign head_entry = entry_mem[head_reg];
    assign head_valid = (count_reg != '0);
    assign count      = count_reg;
    assign idx_sum    = {1'b0, head_entry.idx} + take;
    assign pop        = head_valid && (take != '0) && (idx_sum >= IDX_W'(FQ_FETCH_WORDS));

    // Pointer and occupancy bookkeeping; flush empties the queue outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (pop) begin
                head_reg <= ptr_inc(head_reg);
            end
            if (push) begin
                tail_reg <= ptr_inc(tail_reg);
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Entry storage: partial consume rewrites the head index, push fills the tail.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (head_valid && (take != '0) && !pop) begin
                entry_mem[head_reg].idx <= idx_sum[FQ_OFF_W-1:0];
            end
            if (push) begin
                entry_mem[tail_reg] <= push_entry;
            end
        end
    end

    // A push into a full queue that is not popping the same cycle loses data.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) begin
            assert (count_reg < CNT_W'(DEPTH) || pop);
        end
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: issues bundle-aligned memory requests under a
// credit limit, buffers in-order responses, and feeds up to ISSUE_W words per
// cycle from the head bundle to decode. Redirect flushes everything and
// discards responses that belong to requests issued before it.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int          FETCH_WORDS     = FQ_FETCH_WORDS,
    parameter int          ISSUE_W         = 2,
    parameter int          QUEUE_DEPTH     = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               redirect_valid,
    input  logic [31:0]                        redirect_target,
    output logic                               mem_req_valid,
    input  logic                               mem_req_ready,
    output logic [31:0]                        mem_req_addr,
    input  logic                               mem_resp_valid,
    input  logic [FETCH_WORDS*INST_W-1:0]      mem_resp_data,
    output logic [ISSUE_W-1:0]                 dec_valid,
    output logic [ISSUE_W*INST_W-1:0]          dec_inst,
    output logic [ISSUE_W*INST_W-1:0]          dec_pc,
    input  logic [$clog2(ISSUE_W+1)-1:0]       dec_take,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   q_count
);

    localparam int          OFF_W        = $clog2(FETCH_WORDS);
    localparam int          IDX_W        = OFF_W + 1;
    localparam int          CNT_W        = $clog2(QUEUE_DEPTH + 1);
    localparam int          OUT_W        = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] BUNDLE_BYTES = 32'(FETCH_WORDS * 4);

    logic [31:0]      fetch_pc_reg;
    logic [31:0]      resp_base_reg;
    logic [OUT_W-1:0] outstanding_reg;
    logic [OUT_W-1:0] drop_cnt_reg;
    logic [OFF_W-1:0] pending_off_reg;

    logic             credit_ok;
    logic             req_fire;
    logic             resp_push;
    logic [IDX_W-1:0] q_take;
    logic [CNT_W-1:0] q_cnt;
    fq_entry_t        push_entry;
    fq_entry_t        head_entry;
    logic             head_valid;
    logic [INST_W-1:0] head_words [FETCH_WORDS];

    // Outstanding requests are counted against queue space so every
    // response is guaranteed a slot when it lands.
    assign credit_ok     = (int'(q_cnt) + int'(outstanding_reg) < QUEUE_DEPTH) &&
                           (int'(outstanding_reg) < MAX_OUTSTANDING);
    assign mem_req_valid = rst_n && !redirect_valid && credit_ok;
    assign mem_req_addr  = bundle_align(fetch_pc_reg);
    assign req_fire      = mem_req_valid && mem_req_ready;

    // Responses from before the last redirect, or in the redirect cycle itself, are stale.
    assign resp_push = mem_resp_valid && !redirect_valid && (drop_cnt_reg == '0);

    assign push_entry.data = mem_resp_data;
    assign push_entry.base = resp_base_reg;
    assign push_entry.idx  = pending_off_reg;

    assign q_take  = redirect_valid ? '0 : IDX_W'(dec_take);
    assign q_count = q_cnt;

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (resp_push),
        .push_entry (push_entry),
        .take       (q_take),
        .head_entry (head_entry),
        .head_valid (head_valid),
        .count      (q_cnt)
    );

    // Fetch PC, credit, drop and response-address tracking.
    // resp_base_reg follows the address of the next response that will be kept:
    // requests are sequential from the last redirect and responses are in order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg    <= RESET_PC;
            resp_base_reg   <= bundle_align(RESET_PC);
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            pending_off_reg <= RESET_PC[OFF_W+1:2];
        end else if (redirect_valid) begin
            fetch_pc_reg    <= redirect_target;
            resp_base_reg   <= bundle_align(redirect_target);
            pending_off_reg <= redirect_target[OFF_W+1:2];
            outstanding_reg <= outstanding_reg - OUT_W'(mem_resp_valid);
            drop_cnt_reg    <= outstanding_reg - OUT_W'(mem_resp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_reg <= bundle_align(fetch_pc_reg) + BUNDLE_BYTES;
            end
            outstanding_reg <= outstanding_reg + OUT_W'(req_fire) - OUT_W'(mem_resp_valid);
            if (mem_resp_valid && (drop_cnt_reg != '0)) begin
                drop_cnt_reg <= drop_cnt_reg - OUT_W'(1);
            end
            if (resp_push) begin
                resp_base_reg   <= resp_base_reg + BUNDLE_BYTES;
                pending_off_reg <= '0;
            end
        end
    end

    // Split the head bundle into addressable words.
    genvar gi;
    generate
        for (gi = 0; gi < FETCH_WORDS; gi++) begin : g_word
            assign head_words[gi] = head_entry.data[gi*INST_W +: INST_W];
        end

        // Decode slots read consecutive words of the head bundle only.
        for (gi = 0; gi < ISSUE_W; gi++) begin : g_slot
            logic [IDX_W-1:0] word_idx;
            assign word_idx = {1'b0, head_entry.idx} + IDX_W'(gi);
            assign dec_valid[gi] = head_valid && (word_idx < IDX_W'(FETCH_WORDS));
            assign dec_inst[gi*INST_W +: INST_W] = head_words[word_idx[OFF_W-1:0]];
            assign dec_pc[gi*INST_W +: INST_W]   = head_entry.base + 32'({word_idx, 2'b00});
        end
    endgenerate

    // Interface protocol checks: decode may not take more than is offered,
    // memory may not answer unrequested, and the package sizing must match.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (FETCH_WORDS == FQ_FETCH_WORDS);
            if (!redirect_valid) begin
                assert ($countones(dec_valid) >= int'(dec_take));
            end
            if (mem_resp_valid) begin
                assert (outstanding_reg != '0);
            end
        end
    end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised next-generation instruction fetch front end for the compute unit.
- Issues aligned FETCH_WORDS-wide requests to instruction memory over a valid/ready request channel and an in-order response channel, with up to MAX_OUTSTANDING requests in flight.
- Buffers returned bundles in a QUEUE_DEPTH-entry queue and presents up to ISSUE_W instructions per cycle to decode.
- On redirect it flushes the queue and discards stale in-flight responses.

Parameters:
FETCH_WORDS, 2, 32-bit words per fetch bundle; power of 2, ≥2.
ISSUE_W, 2, decode slots per cycle; 1..FETCH_WORDS.
QUEUE_DEPTH, 4, bundle entries in the queue; ≥2.
MAX_OUTSTANDING, 2, maximum in-flight memory requests; 1..QUEUE_DEPTH.
RESET_PC, 32'h0, fetch PC after reset.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
redirect_valid  in  1  flush and refetch request from branch resolution or prediction.
redirect_target  in  32  new PC; word-aligned; bits [1:0] ignored.
mem_req_valid  out  1  fetch request.
mem_req_ready  in  1  memory accepts the request.
mem_req_addr  out  32  bundle-aligned address (low log2(FETCH_WORDS*4) bits are zero).
mem_resp_valid  in  1  response data valid; responses return in request order.
mem_resp_data  in  FETCH_WORDS*32  bundle; word i is at address +4i.
dec_valid  out  ISSUE_W  per-slot instruction valid.
dec_inst  out  ISSUE_W*32  slot i is at [32i+31:32i].
dec_pc  out  ISSUE_W*32  PC of each slot.
dec_take  in  $clog2(ISSUE_W+1)  number of leading slots consumed this cycle; 0 means stall.
q_count  out  $clog2(QUEUE_DEPTH+1)  occupied queue entries.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - fetch_pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0; pending_off=RESET_PC word index.
  - Outputs: mem_req_valid=0, dec_valid=0, q_count=0.
  - mem_req_valid may assert from the first clock after deassertion.
- Request issue:
  - mem_req_valid = !redirect_valid && (q_count + outstanding < QUEUE_DEPTH) && (outstanding < MAX_OUTSTANDING).
  - mem_req_addr = fetch_pc with the bundle offset bits zeroed.
  - On fire (valid&&ready): fetch_pc <= aligned(fetch_pc) + FETCH_WORDS*4; outstanding+1.
  - Withdrawal: a request may be withdrawn by redirect. Memory treats only valid&&ready as accepted.
- Responses:
  - Each mem_resp_valid decrements outstanding. A simultaneous request fire and response leaves it unchanged.
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Otherwise push an entry {data, base = that request's aligned address, idx = pending_off}, then clear pending_off to 0.
  - The credit rule guarantees no push to a full queue. Assert on violation.
- Decode presentation (head entry only; slots never span entries):
  - dec_valid[i] = head valid && (head.idx + i < FETCH_WORDS).
  - dec_inst[i] = word head.idx+i.
  - dec_pc[i] = base + 4*(head.idx+i).
  - Outputs are combinational from queue registers: a response pushed at cycle N is visible at N+1.
- Consume:
  - dec_take ≤ popcount(dec_valid); assert on violation.
  - Head idx += dec_take. If idx reaches FETCH_WORDS, pop the entry. Pop and push in the same cycle is legal, including when the queue is full.
- Redirect (highest priority):
  - Queue emptied and dec_take ignored; dec_valid=0 in the following cycle.
  - fetch_pc <= redirect_target; pending_off <= redirect_target word-in-bundle index.
  - drop_cnt <= outstanding - mem_resp_valid. Any response in the redirect cycle is discarded.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Address arithmetic is 32-bit and wraps at 2^32 silently.
- Reset mid-operation: all state clears immediately. Responses to requests accepted before reset are the memory's responsibility to cancel.

Decomposition:
- Shared package fetch_pkg:
  - fq_entry_t struct {logic [FETCH_WORDS*32-1:0] data; logic [31:0] base; logic [$clog2(FETCH_WORDS)-1:0] idx}.
  - INST_W=32 constant.
  - Function bundle_align(addr).
- One natural sub-module: fetch_queue, a circular FIFO of fq_entry_t with head/tail pointers, count, flush, and in-place head idx update.
- Request/credit/drop control stays in the top level.

Test Plan:
1. Reset release, mem_req_ready=1, 1-cycle memory → addresses 0x0, 0x8, 0x10; dec_pc {0x0,0x4}, then {0x8,0xC}; dec_take=2 each cycle gives steady 2 instructions/cycle.
2. Decode stall dec_take=0 → 4 entries plus 0 outstanding, then mem_req_valid=0; q_count=4; resume gives no lost or duplicated PCs.
3. Redirect to 0x104 with 2 outstanding → both responses discarded; next request addr 0x100; first slot dec_pc=0x104, dec_valid=2'b01.
4. Partial consume: head {0x20,0x24}, dec_take=1 → next cycle dec_valid=2'b01, dec_pc[0]=0x24; take=1 pops the entry.
5. Redirect in the same cycle as mem_resp_valid and dec_take=2 → that response is dropped, the queue is empty next cycle, drop_cnt=outstanding-1.
6. rst_n asserted mid-stream (asynchronously, between edges) → mem_req_valid, dec_valid and q_count go to 0 without waiting for a clock edge; fetch restarts at RESET_PC.
